sort_job_sched: RTL

//   Round-robin scheduler that shares one sort engine (sort control FSM + count unit + pop/read unit) among NUM_REQ clients.

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_rr_pick.sv | 32 +++
 rtl/sort_job_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort-engine job scheduler: state encoding and
// the grant-index width helper.
package sort_pkg;

  localparam int SCHED_STATE_W = 2;

  typedef enum logic [SCHED_STATE_W-1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_WR   = 2'd1,
    SCHED_RD   = 2'd2
  } sched_state_t;

  // A 2-client build still needs a 1-bit index.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping modulo NUM_REQ.
module sort_rr_pick
  import sort_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx    = '0;
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
    if (any) onehot = NUM_REQ'(1) << id;
  end

endmodule

// File: rtl/sort_job_sched.sv
// Round-robin owner of a shared sort engine: grants one client per job,
// sequences the engine strobes and returns a per-client done pulse.
// Optional watchdog abort is built when SORT_SCHED_TIMEOUT_EN is defined.
module sort_job_sched
  import sort_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = id_width(NUM_REQ),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] input_done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               busy_o,
  output logic               eng_vld_o,
  output logic               eng_input_done_o,
  input  logic               eng_rd_start_i,
  input  logic               eng_rd_done_i,
`ifdef SORT_SCHED_TIMEOUT_EN
  output logic               eng_abort_o,
  output logic               timeout_o,
`endif
  output logic [NUM_REQ-1:0] done_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("sort_job_sched: unsupported NUM_REQ/TIMEOUT_CYC");
  end

  sched_state_t        state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     ptr_next;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;

  sort_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_i),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  assign eng_input_done_o = (state == SCHED_WR) && input_done_i[gnt_id_o];
  assign ptr_next = (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;

`ifdef SORT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_evt;
  logic             wd_expire;

  assign wd_evt = ((state == SCHED_WR) && (eng_input_done_o || eng_rd_start_i)) ||
                  ((state == SCHED_RD) && eng_rd_done_i);
  // Expire on the cycle the count would reach the limit, so the abort is
  // registered on the same edge that releases the grant.
  assign wd_expire = (state != SCHED_IDLE) && !wd_evt &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCHED_IDLE;
      gnt_o     <= '0;
      gnt_id_o  <= '0;
      busy_o    <= 1'b0;
      eng_vld_o <= 1'b0;
      done_o    <= '0;
      rr_ptr    <= '0;
`ifdef SORT_SCHED_TIMEOUT_EN
      eng_abort_o <= 1'b0;
      timeout_o   <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      eng_vld_o <= 1'b0;
      done_o    <= '0;
`ifdef SORT_SCHED_TIMEOUT_EN
      eng_abort_o <= 1'b0;
      if (state == SCHED_IDLE || wd_evt) wd_cnt <= '0;
      else                               wd_cnt <= wd_cnt + 1'b1;
`endif
      case (state)
        SCHED_IDLE: begin
          if (pick_any) begin
            state     <= SCHED_WR;
            gnt_o     <= pick_onehot;
            gnt_id_o  <= pick_id;
            busy_o    <= 1'b1;
            eng_vld_o <= 1'b1;
`ifdef SORT_SCHED_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
          end
        end
        SCHED_WR: begin
          if (eng_rd_start_i) begin
            state <= SCHED_RD;
          end
`ifdef SORT_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            state       <= SCHED_IDLE;
            gnt_o       <= '0;
            busy_o      <= 1'b0;
            rr_ptr      <= ptr_next;
            eng_abort_o <= 1'b1;
            timeout_o   <= 1'b1;
          end
`endif
        end
        SCHED_RD: begin
          if (eng_rd_done_i) begin
            state  <= SCHED_IDLE;
            done_o <= gnt_o;
            gnt_o  <= '0;
            busy_o <= 1'b0;
            rr_ptr <= ptr_next;
          end
`ifdef SORT_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            state       <= SCHED_IDLE;
            gnt_o       <= '0;
            busy_o      <= 1'b0;
            rr_ptr      <= ptr_next;
            eng_abort_o <= 1'b1;
            timeout_o   <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= SCHED_IDLE;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
